operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DB_COUNT, default 500000, SHALL be the debounce stability period in clock cycles (legal range 2 to 2^20-1).
REQ-002 Port list SHALL be exactly as follows, clock and reset first:
- clk  input  1  single system clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-low reset.
- sw  input  4  operand value from the slide switches; asynchronous to clk.
- btn  input  1  raw load pushbutton; asynchronous, bouncy, active-high.
- a  output  4  latched operand A; feeds the multiplier and display digit 1.
- b  output  4  latched operand B; feeds the multiplier and display digit 2.
- valid  output  1  high when a and b are both loaded and stable.
- phase  output  2  current FSM state encoding, drives the status LEDs.

Function
REQ-003 btn SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-004 The debouncer SHALL hold a register stable and a counter cnt at least 20 bits wide.
REQ-005 Debouncer update rule, applied each edge:
- sync2==stable: cnt<=0.
- sync2!=stable and cnt<DB_COUNT-1: cnt<=cnt+1.
- sync2!=stable and cnt==DB_COUNT-1: stable<=sync2 and cnt<=0.
REQ-006 press SHALL be stable AND NOT stable_d, where stable_d is stable delayed one cycle; it is high for exactly one cycle per debounced rising edge.
REQ-007 Latency: if btn is first sampled high by sync1 at edge N and then held, stable SHALL rise at edge N+DB_COUNT+1 and the FSM action SHALL occur at edge N+DB_COUNT+2.
REQ-008 Any bounce shorter than DB_COUNT consecutive mismatching cycles SHALL produce no press; button release SHALL be debounced by the same rule.
REQ-009 A held button SHALL produce exactly one press.
REQ-010 FSM states and phase encoding SHALL be LOAD_A=2'b00, LOAD_B=2'b01, SHOW=2'b10; 2'b11 is illegal and SHALL return to LOAD_A on the next edge with valid<=0.
REQ-011 LOAD_A with press: a<=sw; next state LOAD_B.
REQ-012 LOAD_B with press: b<=sw; valid<=1; next state SHOW.
REQ-013 SHOW with press: valid<=0; next state LOAD_A; a and b hold their values.
REQ-014 Without press, the state, a, b and valid SHALL hold.
REQ-015 The value captured SHALL be sw as sampled at the capture edge; changes to sw at any other time SHALL have no effect.
REQ-016 a and b SHALL change only on a capture edge, and valid SHALL never be high while the state is LOAD_A or LOAD_B.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-018 When clr==0 at a rising edge, the block SHALL set a=0, b=0, valid=0, phase=LOAD_A, sync1=sync2=stable=stable_d=0 and cnt=0.
REQ-019 Reset SHALL override any simultaneous press; a button press that is mid-debounce SHALL be discarded.
REQ-020 After clr returns high, a button still held SHALL be treated as a new press; it is debounced from cnt=0 and yields one press.

Verification (DB_COUNT=4)
REQ-021 Reset release, sw=4'h3, btn held high from edge N -> a=4'h3 and phase=01 at edge N+6, with no earlier change.
REQ-022 Full sequence -> load A=4'h9, then B=4'hE -> valid=1 and phase=10, a/b = 9/E. A third press -> valid=0, phase=00, a/b still 9/E.
REQ-023 Bounce: btn high 3 cycles, low 1, high 2, low -> no press and phase unchanged. Then btn held 10 cycles -> exactly one capture.
REQ-024 sw toggles between 4'h5 and 4'hA every cycle during debounce -> captured a equals the sw value present at capture edge N+6.
REQ-025 clr=0 asserted one cycle before the capture edge with btn held -> all outputs at reset values. Release clr with btn still high -> one capture occurs DB_COUNT+2 edges later.
REQ-026 Force phase to 2'b11 -> next edge phase=00 and valid=0.

Source files
------------

// File: rtl/operand_loader.sv
// Captures two 4-bit operands from the slide switches on successive debounced
// presses of a bouncy load button, then shows them as a valid pair.
module operand_loader #(
    parameter int DB_COUNT = 500000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       valid,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    localparam logic [19:0] CNT_MAX = 20'(DB_COUNT - 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        stable_q, stable_d;
    logic        stable_dly_q, stable_dly_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        valid_q, valid_d;
    logic        press;

    // A flip of the debounced level needs DB_COUNT consecutive mismatching samples.
    always_comb begin
        sync1_d      = btn;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        cnt_d        = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q >= CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    assign press = stable_q & ~stable_dly_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        case (state_q)
            LOAD_A: begin
                if (press) begin
                    a_d     = sw;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_d     = sw;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= LOAD_A;
            a_q          <= '0;
            b_q          <= '0;
            valid_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            valid_q      <= valid_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign valid = valid_q;
    assign phase = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed and random stimulus for operand_loader, compared each cycle against
// a sample-history model of the debounced button and the load sequence.
module tb_operand_loader;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] a;
    logic [3:0] b;
    logic       valid;
    logic [1:0] phase;

    int total = 0;
    int bad   = 0;

    bit       m_hist[$];
    bit       m_win[$];
    bit       m_stable;
    bit       m_pending;
    bit       m_illegal;
    int       m_phase;
    bit [3:0] m_a;
    bit [3:0] m_b;
    bit       m_valid;

    operand_loader #(.DB_COUNT(DB)) dut (
        .clk   (clk),
        .clr   (clr),
        .sw    (sw),
        .btn   (btn),
        .a     (a),
        .b     (b),
        .valid (valid),
        .phase (phase)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_hist.delete();
        m_win.delete();
        m_stable  = 1'b0;
        m_pending = 1'b0;
        m_phase   = 0;
        m_a       = 4'h0;
        m_b       = 4'h0;
        m_valid   = 1'b0;
    endfunction

    // One rising edge: a debounced level flips once the last DB samples seen
    // after the two-stage synchronizer all disagree with it.
    function automatic void model_edge(input bit c, input bit bb, input bit [3:0] s);
        bit in_s;
        bit all_diff;
        if (!c) begin
            model_reset();
            m_illegal = 1'b0;
            return;
        end
        if (m_illegal) begin
            m_phase   = 0;
            m_valid   = 1'b0;
            m_illegal = 1'b0;
        end else if (m_pending) begin
            case (m_phase)
                0: begin m_a = s; m_phase = 1; end
                1: begin m_b = s; m_valid = 1'b1; m_phase = 2; end
                default: begin m_valid = 1'b0; m_phase = 0; end
            endcase
        end
        m_pending = 1'b0;
        in_s = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
        m_hist.push_back(bb);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_win.push_back(in_s);
        if (m_win.size() > DB) void'(m_win.pop_front());
        if (m_win.size() == DB) begin
            all_diff = 1'b1;
            foreach (m_win[i]) if (m_win[i] == m_stable) all_diff = 1'b0;
            if (all_diff) begin
                m_stable = ~m_stable;
                if (m_stable) m_pending = 1'b1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("a", a, m_a);
        check("b", b, m_b);
        check("valid", {3'b000, valid}, {3'b000, m_valid});
        check("phase", {2'b00, phase}, 4'(m_phase));
    endtask

    // Called at a falling edge; drives inputs, advances one clock, checks.
    task automatic applyStimulus(input bit c, input bit bb, input bit [3:0] s);
        clr = c;
        btn = bb;
        sw  = s;
        @(posedge clk);
        model_edge(c, bb, s);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'h0);
    endtask

    task automatic press_button(input bit [3:0] s);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, s);
        idle(8);
    endtask

    initial begin
        int       k;
        int       changes;
        int       hold;
        logic [1:0] prev;
        bit       lvl;
        bit       cr;

        clr = 1'b0;
        btn = 1'b0;
        sw  = 4'h0;
        m_illegal = 1'b0;
        model_reset();
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF);
        check("rst_a", a, 4'h0);
        check("rst_phase", {2'b00, phase}, 4'h0);

        $display("[TB] first capture latency");
        k = 0;
        do begin
            applyStimulus(1'b1, 1'b1, 4'h3);
            k++;
        end while (phase !== 2'b01 && k < 20);
        check("lat_steps", 4'(k), 4'd7);
        check("lat_a", a, 4'h3);
        applyStimulus(1'b1, 1'b1, 4'h3);
        idle(8);

        $display("[TB] full load sequence");
        press_button(4'hE);
        press_button(4'h1);
        press_button(4'h9);
        press_button(4'hE);
        check("seq_a", a, 4'h9);
        check("seq_b", b, 4'hE);
        check("seq_valid", {3'b000, valid}, 4'h1);
        check("seq_phase", {2'b00, phase}, 4'h2);
        press_button(4'h4);
        check("third_valid", {3'b000, valid}, 4'h0);
        check("third_phase", {2'b00, phase}, 4'h0);
        check("third_a", a, 4'h9);
        check("third_b", b, 4'hE);

        $display("[TB] bounce rejection");
        applyStimulus(1'b1, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b0, 4'h7);
        applyStimulus(1'b1, 1'b1, 4'h7);
        applyStimulus(1'b1, 1'b1, 4'h7);
        idle(8);
        check("bounce_phase", {2'b00, phase}, 4'h0);
        changes = 0;
        for (int i = 0; i < 18; i++) begin
            prev = phase;
            applyStimulus(1'b1, (i < 10), 4'h7);
            if (phase !== prev) changes++;
        end
        check("held_presses", 4'(changes), 4'd1);
        check("held_a", a, 4'h7);

        $display("[TB] switch toggling during debounce");
        press_button(4'h2);
        press_button(4'h2);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, (i % 2 == 1) ? 4'h5 : 4'hA);
        idle(8);
        check("toggle_a", a, 4'h5);

        $display("[TB] reset during debounce");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 4'hC);
        applyStimulus(1'b0, 1'b1, 4'hC);
        check("clr_a", a, 4'h0);
        check("clr_b", b, 4'h0);
        check("clr_valid", {3'b000, valid}, 4'h0);
        check("clr_phase", {2'b00, phase}, 4'h0);
        k = 0;
        do begin
            applyStimulus(1'b1, 1'b1, 4'hC);
            k++;
        end while (phase !== 2'b01 && k < 20);
        check("clr_steps", 4'(k), 4'd7);
        check("clr_cap_a", a, 4'hC);
        applyStimulus(1'b1, 1'b1, 4'hC);
        idle(8);

        $display("[TB] illegal state recovery");
        press_button(4'h6);
        check("pre_ill_valid", {3'b000, valid}, 4'h1);
        force dut.state_q = 2'b11;
        #1;
        release dut.state_q;
        m_illegal = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h0);
        check("ill_phase", {2'b00, phase}, 4'h0);
        check("ill_valid", {3'b000, valid}, 4'h0);

        $display("[TB] random stimulus");
        for (int it = 0; it < 60; it++) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 9);
            for (int j = 0; j < hold; j++) begin
                cr = ($urandom_range(0, 39) != 0);
                applyStimulus(cr, lvl, 4'($urandom_range(0, 15)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
